// File: rtl/serial_paralelo_if.sv
// Serial-side bus of the deserializer: one bit in, recovered byte plus status out.
// Optional byte counter present when SERPAR_BYTE_CNT_EN is defined.
interface serial_paralelo_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef SERPAR_BYTE_CNT_EN
    logic [15:0] byte_cnt;

    modport master (output data_in, input data_out, valid_out, active, byte_cnt);
    modport slave  (input data_in, output data_out, valid_out, active, byte_cnt);
`else
    modport master (output data_in, input data_out, valid_out, active);
    modport slave  (input data_in, output data_out, valid_out, active);
`endif
endinterface

// File: rtl/serial_paralelo.sv
// MSB-first deserializer that locks byte alignment on LOCK_COUNT aligned commas, then emits non-comma bytes.
// Latency: outputs update on the edge sampling a byte's LSB; no backpressure (free-running bit stream).
// SERPAR_BYTE_CNT_EN adds a saturating count of emitted bytes on byte_cnt.
module serial_paralelo #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    serial_paralelo_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

    state_t      state_q;
    // Only the seven newest bits are needed; the eighth is the incoming data_in.
    logic [6:0]  sr_q;
    logic [7:0]  sr_d;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  bc_cnt_q;
    logic [7:0]  data_out_q;
    logic        valid_q;
    logic        active_q;
    logic        boundary;
    logic        is_comma;
`ifdef SERPAR_BYTE_CNT_EN
    logic [15:0] byte_cnt_q;
`endif

    assign sr_d     = {sr_q, bus.data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (sr_d == COMMA);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            bc_cnt_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
`ifdef SERPAR_BYTE_CNT_EN
            byte_cnt_q <= '0;
`endif
        end else begin
            sr_q      <= sr_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            valid_q   <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt_q <= 3'd0;
                        bc_cnt_q  <= 4'd1;
                        state_q   <= ALIGN;
                    end
                end
                ALIGN: begin
                    // A comma that straddled two bytes fails here, one byte later.
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt_q <= bc_cnt_q + 4'd1;
                            if (bc_cnt_q + 4'd1 == LOCK_TGT) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            bc_cnt_q <= 4'd0;
                            state_q  <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary && !is_comma) begin
                        data_out_q <= sr_d;
                        valid_q    <= 1'b1;
`ifdef SERPAR_BYTE_CNT_EN
                        if (byte_cnt_q != 16'hFFFF) begin
                            byte_cnt_q <= byte_cnt_q + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;
`ifdef SERPAR_BYTE_CNT_EN
    assign bus.byte_cnt  = byte_cnt_q;
`endif

endmodule
